// File: rtl/ula_arbiter.sv
// Two-requester round-robin front end for one shared ALU: IDLE -> EXEC -> RESP per operation.
// Optional macro ULA_DIVZERO_CHK_EN turns divide-by-zero into an error response instead of passing it to the ALU.
module ula_arbiter #(
  parameter logic [3:0] FX_MAX = 4'd5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  input  logic               req1_valid,
  output logic               req0_ready,
  output logic               req1_ready,
  input  logic signed [31:0] req0_a,
  input  logic signed [31:0] req0_b,
  input  logic signed [31:0] req1_a,
  input  logic signed [31:0] req1_b,
  input  logic [3:0]         req0_fx,
  input  logic [3:0]         req1_fx,
  output logic               rsp0_valid,
  output logic               rsp1_valid,
  input  logic               rsp0_ready,
  input  logic               rsp1_ready,
  output logic signed [31:0] rsp_result,
  output logic               rsp_zero,
  output logic               rsp_overf,
  output logic               rsp_err,
  output logic signed [31:0] alu_inA,
  output logic signed [31:0] alu_inB,
  output logic [3:0]         alu_fx,
  input  logic signed [31:0] alu_result,
  input  logic               alu_overF,
  input  logic               alu_zero
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                   state_q, state_d;
  logic                     last_grant_q, last_grant_d;
  logic                     owner_q, owner_d;
  logic                     err_pend_q, err_pend_d;
  logic signed [DATA_W-1:0] alu_inA_q, alu_inA_d;
  logic signed [DATA_W-1:0] alu_inB_q, alu_inB_d;
  logic [3:0]               alu_fx_q, alu_fx_d;
  logic signed [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic                     rsp_zero_q, rsp_zero_d;
  logic                     rsp_overf_q, rsp_overf_d;
  logic                     rsp_err_q, rsp_err_d;

  logic                     in_idle, grant0, grant1;
  logic signed [DATA_W-1:0] a_sel, b_sel;
  logic [3:0]               fx_sel;
  logic                     div_zero, op_err, owner_ack;

  // Requester 0 wins contention unless it was the last one served.
  assign in_idle = (state_q == IDLE);
  assign grant0  = in_idle & req0_valid & (~req1_valid | last_grant_q);
  assign grant1  = in_idle & req1_valid & ~grant0;

  assign a_sel  = grant1 ? req1_a  : req0_a;
  assign b_sel  = grant1 ? req1_b  : req0_b;
  assign fx_sel = grant1 ? req1_fx : req0_fx;

`ifdef ULA_DIVZERO_CHK_EN
  localparam logic [3:0] FX_DIV = 4'b0011;
  assign div_zero = (fx_sel == FX_DIV) && (b_sel == '0);
`else
  assign div_zero = 1'b0;
`endif

  assign op_err    = (fx_sel > FX_MAX) | div_zero;
  assign owner_ack = owner_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    err_pend_d   = err_pend_q;
    alu_inA_d    = alu_inA_q;
    alu_inB_d    = alu_inB_q;
    alu_fx_d     = alu_fx_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_overf_d  = rsp_overf_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (grant0 | grant1) begin
          alu_inA_d    = a_sel;
          alu_inB_d    = b_sel;
          // A guarded divide still drives the ALU, but with a harmless code.
          alu_fx_d     = div_zero ? 4'b0000 : fx_sel;
          err_pend_d   = op_err;
          owner_d      = grant1;
          last_grant_d = grant1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        if (err_pend_q) begin
          rsp_result_d = '0;
          rsp_zero_d   = 1'b0;
          rsp_overf_d  = 1'b0;
          rsp_err_d    = 1'b1;
        end else begin
          rsp_result_d = alu_result;
          rsp_zero_d   = alu_zero;
          rsp_overf_d  = alu_overF;
          rsp_err_d    = 1'b0;
        end
        state_d = RESP;
      end
      RESP: begin
        if (owner_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      err_pend_q   <= 1'b0;
      alu_inA_q    <= '0;
      alu_inB_q    <= '0;
      alu_fx_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_overf_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      err_pend_q   <= err_pend_d;
      alu_inA_q    <= alu_inA_d;
      alu_inB_q    <= alu_inB_d;
      alu_fx_q     <= alu_fx_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_overf_q  <= rsp_overf_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = (state_q == RESP) & ~owner_q;
  assign rsp1_valid = (state_q == RESP) & owner_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_overf  = rsp_overf_q;
  assign rsp_err    = rsp_err_q;
  assign alu_inA    = alu_inA_q;
  assign alu_inB    = alu_inB_q;
  assign alu_fx     = alu_fx_q;

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed bench for ula_arbiter with a small behavioural ALU attached to the alu_* ports.
module tb_ula_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               req0_valid, req1_valid, req0_ready, req1_ready;
  logic signed [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]         req0_fx, req1_fx;
  logic               rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic signed [31:0] rsp_result;
  logic               rsp_zero, rsp_overf, rsp_err;
  logic signed [31:0] alu_inA, alu_inB;
  logic [3:0]         alu_fx;
  logic signed [31:0] alu_result;
  logic               alu_overF, alu_zero;

  ula_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_fx(req0_fx), .req1_fx(req1_fx),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_overf(rsp_overf), .rsp_err(rsp_err),
    .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_fx(alu_fx),
    .alu_result(alu_result), .alu_overF(alu_overF), .alu_zero(alu_zero)
  );

  // External ALU: 0 add, 1 sub, 2 or, 3 div (b==0 -> all ones + overflow), 4 and, 5 xor.
  always_comb begin
    alu_result = '0;
    alu_overF  = 1'b0;
    case (alu_fx)
      4'd0: begin
        alu_result = alu_inA + alu_inB;
        alu_overF  = (alu_inA[31] == alu_inB[31]) && (alu_result[31] != alu_inA[31]);
      end
      4'd1: begin
        alu_result = alu_inA - alu_inB;
        alu_overF  = (alu_inA[31] != alu_inB[31]) && (alu_result[31] != alu_inA[31]);
      end
      4'd2: alu_result = alu_inA | alu_inB;
      4'd3: begin
        if (alu_inB == 0) begin
          alu_result = -32'sd1;
          alu_overF  = 1'b1;
        end else begin
          alu_result = alu_inA / alu_inB;
        end
      end
      4'd4: alu_result = alu_inA & alu_inB;
      4'd5: alu_result = alu_inA ^ alu_inB;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == 0);
  end

  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called in IDLE one time unit after an edge with the request inputs already set.
  task automatic serve(input logic own, input logic [3:0] efx, input logic [31:0] eres,
                       input logic ez, input logic eo, input logic ee);
    #1;
    chk("req0_ready", req0_ready, own == 1'b0);
    chk("req1_ready", req1_ready, own == 1'b1);
    cyc();
    chk("alu_fx", alu_fx, efx);
    chk("ready_exec", {req1_ready, req0_ready}, 0);
    chk("rsp_valid_exec", {rsp1_valid, rsp0_valid}, 0);
    cyc();
    chk("rsp0_valid", rsp0_valid, own == 1'b0);
    chk("rsp1_valid", rsp1_valid, own == 1'b1);
    chk("rsp_result", rsp_result, eres);
    chk("rsp_zero", rsp_zero, ez);
    chk("rsp_overf", rsp_overf, eo);
    chk("rsp_err", rsp_err, ee);
    if (own) rsp1_ready = 1'b1;
    else     rsp0_ready = 1'b1;
    cyc();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    chk("rsp_valid_done", {rsp1_valid, rsp0_valid}, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_alu_inA"}, alu_inA, 0);
    chk({tag, "_alu_inB"}, alu_inB, 0);
    chk({tag, "_alu_fx"}, alu_fx, 0);
    chk({tag, "_rsp_result"}, rsp_result, 0);
    chk({tag, "_flags"}, {rsp_zero, rsp_overf, rsp_err}, 0);
    chk({tag, "_rsp_valid"}, {rsp1_valid, rsp0_valid}, 0);
  endtask

  initial begin
    rst_n = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0; req0_fx = 0; req1_fx = 0;
    #1 rst_n = 1'b0;
    #1;
    chk_zero_outputs("reset");
    chk("reset_ready", {req1_ready, req0_ready}, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Single requester add: 7 + 5
    req0_a = 7; req0_b = 5; req0_fx = 4'd0; req0_valid = 1;
    #1;
    chk("single_ready0", req0_ready, 1);
    cyc();
    req0_valid = 0;
    chk("single_alu_inA", alu_inA, 7);
    chk("single_alu_inB", alu_inB, 5);
    chk("single_rsp0_exec", rsp0_valid, 0);
    cyc();
    chk("single_rsp0_valid", rsp0_valid, 1);
    chk("single_result", rsp_result, 12);
    chk("single_flags", {rsp_zero, rsp_overf, rsp_err}, 0);
    rsp0_ready = 1;
    cyc();
    rsp0_ready = 0;
    chk("single_done", rsp0_valid, 0);

    // Contention from reset: req0 first, then req1; non-owner ready ignored
    do_reset();
    req0_a = 3; req0_b = 3; req0_fx = 4'd1;
    req1_a = 32'hF0; req1_b = 32'h0F; req1_fx = 4'd4;
    req0_valid = 1; req1_valid = 1;
    serve(1'b0, 4'd1, 0, 1, 0, 0);
    #1;
    chk("c_ready1", {req1_ready, req0_ready}, 2'b10);
    cyc();
    cyc();
    chk("c_rsp1_valid", rsp1_valid, 1);
    chk("c_result", rsp_result, 0);
    chk("c_zero", rsp_zero, 1);
    rsp0_ready = 1;
    cyc();
    rsp0_ready = 0;
    chk("c_nonowner_ignored", rsp1_valid, 1);
    rsp1_ready = 1;
    cyc();
    rsp1_ready = 0;
    chk("c_done", {rsp1_valid, rsp0_valid}, 0);

    // Both held valid: grants alternate 0,1,0,1; req1 overflows
    req0_a = 100; req0_b = -30; req0_fx = 4'd0;
    req1_a = 32'sh7FFF_FFFF; req1_b = 1; req1_fx = 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) serve(1'b0, 4'd0, 70, 0, 0, 0);
      else            serve(1'b1, 4'd0, 32'h8000_0000, 0, 1, 0);
    end
    req0_valid = 0; req1_valid = 0;

    // Stalled response: held 5 cycles, req1 waits
    req0_a = 9; req0_b = 4; req0_fx = 4'd1; req0_valid = 1;
    #1;
    chk("stall_ready0", req0_ready, 1);
    cyc();
    req0_valid = 0;
    req1_a = 20; req1_b = 22; req1_fx = 4'd0; req1_valid = 1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("stall_rsp0_valid", rsp0_valid, 1);
      chk("stall_result", rsp_result, 5);
      chk("stall_ready1", req1_ready, 0);
      cyc();
    end
    rsp0_ready = 1;
    cyc();
    rsp0_ready = 0;
    chk("stall_idle_rsp0", rsp0_valid, 0);
    chk("stall_idle_ready1", req1_ready, 1);
    serve(1'b1, 4'd0, 42, 0, 0, 0);
    req1_valid = 0;

    // Error codes and FX_MAX boundary
    req0_valid = 1;
    req0_a = 5;  req0_b = 5; req0_fx = 4'd9; serve(1'b0, 4'd9, 0, 0, 0, 1);
    req0_a = 6;  req0_b = 3; req0_fx = 4'd5; serve(1'b0, 4'd5, 5, 0, 0, 0);
    req0_a = 6;  req0_b = 3; req0_fx = 4'd6; serve(1'b0, 4'd6, 0, 0, 0, 1);
    req0_a = 10; req0_b = 3; req0_fx = 4'd3; serve(1'b0, 4'd3, 3, 0, 0, 0);
    req0_a = 10; req0_b = 0; req0_fx = 4'd3;
`ifdef ULA_DIVZERO_CHK_EN
    serve(1'b0, 4'd0, 0, 0, 0, 1);
`else
    serve(1'b0, 4'd3, 32'hFFFF_FFFF, 0, 1, 0);
`endif
    req0_valid = 0;

    // Reset while in RESP drops the response
    req1_a = 1; req1_b = 2; req1_fx = 4'd0; req1_valid = 1;
    cyc();
    req1_valid = 0;
    cyc();
    chk("rr_rsp1_valid", rsp1_valid, 1);
    chk("rr_result", rsp_result, 3);
    #2 rst_n = 1'b0;
    #1;
    chk_zero_outputs("rr");
    cyc();
    rst_n = 1'b1;
    cyc();
    req0_a = 4; req0_b = 4; req0_fx = 4'd1;
    req1_a = 8; req1_b = 1; req1_fx = 4'd0;
    req0_valid = 1; req1_valid = 1;
    serve(1'b0, 4'd1, 0, 1, 0, 0);
    req0_valid = 0; req1_valid = 0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
